// File: rtl/system_run_sequencer_if.sv
// Control-register port of the run sequencer: one write channel and one read channel,
// each a req/ack handshake.
interface system_run_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ctrl_write_req;
  logic                  ctrl_write_ack;
  logic [1:0]            ctrl_write_index;
  logic [DATA_WIDTH-1:0] ctrl_write_data;
  logic                  ctrl_read_req;
  logic                  ctrl_read_ack;
  logic [1:0]            ctrl_read_index;
  logic [DATA_WIDTH-1:0] ctrl_read_data;

  modport master (
    output ctrl_write_req, ctrl_write_index, ctrl_write_data,
    input  ctrl_write_ack,
    output ctrl_read_req, ctrl_read_index,
    input  ctrl_read_ack, ctrl_read_data
  );

  modport slave (
    input  ctrl_write_req, ctrl_write_index, ctrl_write_data,
    output ctrl_write_ack,
    input  ctrl_read_req, ctrl_read_index,
    output ctrl_read_ack, ctrl_read_data
  );
endinterface

// File: rtl/system_run_sequencer.sv
// Drives a target through reset, enable, execute, then polls its halted flag and shuts it down.
// Define SYSTEM_RUN_SEQUENCER_TIMEOUT_EN to let timeout_cycles end the POLL phase.
module system_run_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES = 4,
  parameter int unsigned DATA_WIDTH        = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] timeout_cycles,
  output logic                  busy,
  output logic                  done,
  output logic                  timed_out,
  output logic                  aborted,
  output logic [DATA_WIDTH-1:0] cycle_count,
  system_run_sequencer_if.master ctrl
);

  localparam logic [1:0] IdxReset   = 2'd0;
  localparam logic [1:0] IdxEnable  = 2'd1;
  localparam logic [1:0] IdxExecute = 2'd2;
  localparam logic [1:0] IdxHalted  = 2'd3;
  localparam logic [7:0] HoldLast   = 8'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StRstOn, StRstHold, StRstOff, StEnOn, StExeOn, StPoll, StExeOff, StEnOff, StDone
  } state_e;

  state_e                state_q, state_d, wr_next;
  logic [7:0]            hold_q, hold_d;
  logic [DATA_WIDTH-1:0] count_q, count_d, count_inc;
  logic                  abort_pend_q, abort_pend_d;
  logic                  aborted_q, aborted_d;
  logic                  timed_out_q, timed_out_d;
  logic                  wr_req, wr_val, rd_req, abortable, halted, timeout_hit;
  logic [1:0]            wr_index;

  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
  assign halted    = ctrl.ctrl_read_ack & ctrl.ctrl_read_data[0];

`ifdef SYSTEM_RUN_SEQUENCER_TIMEOUT_EN
  assign timeout_hit = (timeout_cycles != '0) && (count_inc >= timeout_cycles);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles;
  assign timeout_hit    = 1'b0;
`endif

  logic unused_read_data;
  assign unused_read_data = ^ctrl.ctrl_read_data[DATA_WIDTH-1:1];

  always_comb begin
    state_d      = state_q;
    hold_d       = '0;
    count_d      = count_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    timed_out_d  = timed_out_q;
    wr_req       = 1'b0;
    wr_index     = IdxReset;
    wr_val       = 1'b0;
    wr_next      = state_q;
    rd_req       = 1'b0;
    abortable    = 1'b0;

    // Aborts during the bring-up writes wait for the write in flight to be acknowledged.
    if (abort && (state_q inside {StRstOn, StRstHold, StRstOff, StEnOn, StExeOn})) begin
      abort_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        abort_pend_d = 1'b0;
        if (start) begin
          state_d     = StRstOn;
          count_d     = '0;
          aborted_d   = 1'b0;
          timed_out_d = 1'b0;
        end
      end
      StRstOn: begin
        {wr_req, wr_index, wr_val, wr_next, abortable} = {1'b1, IdxReset, 1'b1, StRstHold, 1'b1};
      end
      StRstHold: begin
        if (abort || abort_pend_q) begin
          state_d      = StExeOff;
          aborted_d    = 1'b1;
          abort_pend_d = 1'b0;
        end else if (hold_q == HoldLast) begin
          state_d = StRstOff;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      StRstOff: begin
        {wr_req, wr_index, wr_val, wr_next, abortable} = {1'b1, IdxReset, 1'b0, StEnOn, 1'b1};
      end
      StEnOn: begin
        {wr_req, wr_index, wr_val, wr_next, abortable} = {1'b1, IdxEnable, 1'b1, StExeOn, 1'b1};
      end
      StExeOn: begin
        {wr_req, wr_index, wr_val, wr_next, abortable} = {1'b1, IdxExecute, 1'b1, StPoll, 1'b1};
      end
      StPoll: begin
        rd_req  = 1'b1;
        count_d = count_inc;
        // halted outranks abort, abort outranks timeout
        if (halted) begin
          state_d = StExeOff;
        end else if (abort) begin
          state_d   = StExeOff;
          aborted_d = 1'b1;
        end else if (timeout_hit) begin
          state_d     = StExeOff;
          timed_out_d = 1'b1;
        end
      end
      StExeOff: begin
        {wr_req, wr_index, wr_val, wr_next} = {1'b1, IdxExecute, 1'b0, StEnOff};
      end
      StEnOff: begin
        {wr_req, wr_index, wr_val, wr_next} = {1'b1, IdxEnable, 1'b0, StDone};
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (wr_req && ctrl.ctrl_write_ack) begin
      if (abortable && (abort || abort_pend_q)) begin
        state_d      = StExeOff;
        aborted_d    = 1'b1;
        abort_pend_d = 1'b0;
      end else begin
        state_d = wr_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      count_q      <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      timed_out_q  <= timed_out_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign aborted     = aborted_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = count_q;

  assign ctrl.ctrl_write_req   = wr_req;
  assign ctrl.ctrl_write_index = wr_index;
  assign ctrl.ctrl_write_data  = {{(DATA_WIDTH-1){1'b0}}, wr_val};
  assign ctrl.ctrl_read_req    = rd_req;
  assign ctrl.ctrl_read_index  = IdxHalted;

endmodule

// File: tb/tb_system_run_sequencer.sv
// Directed bench for system_run_sequencer: a responsive control-register slave with
// configurable write-ack delay and a halted flag raised on a chosen POLL cycle.
module tb_system_run_sequencer;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] timeout_cycles = '0;
  logic          busy, done, timed_out, aborted;
  logic [DW-1:0] cycle_count;

  system_run_sequencer_if #(.DATA_WIDTH(DW)) ctrl ();

  system_run_sequencer #(
    .RESET_HOLD_CYCLES(4),
    .DATA_WIDTH       (DW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .timeout_cycles(timeout_cycles),
    .busy          (busy),
    .done          (done),
    .timed_out     (timed_out),
    .aborted       (aborted),
    .cycle_count   (cycle_count),
    .ctrl          (ctrl.master)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int ack_delay = 0;
  int halt_at   = 0;   // 1-based POLL cycle on which halted reads 1; 0 = never
  int rd_base   = 0;
  int log_base  = 0;
  int done_base = 0;

  int wcnt = 0, rd_cnt = 0, cyc = 0, done_cnt = 0, stable_err = 0, both_err = 0;
  logic        pend = 1'b0;
  logic [33:0] pend_val = '0;
  logic [33:0] cur_w;
  logic [33:0] wr_log[$];
  int          wr_cyc[$];
  int          wr_wait[$];
  logic [33:0] exp_q[$];

  assign cur_w = {ctrl.ctrl_write_index, ctrl.ctrl_write_data};
  assign ctrl.ctrl_write_ack = ctrl.ctrl_write_req && (wcnt >= ack_delay);
  assign ctrl.ctrl_read_ack  = ctrl.ctrl_read_req;
  assign ctrl.ctrl_read_data = {{(DW-1){1'b0}},
      (halt_at != 0) && ((rd_cnt - rd_base) == halt_at - 1) && (ctrl.ctrl_read_index == 2'd3)};

  // Slave-side monitor: logs accepted writes, ack wait, and handshake stability.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (ctrl.ctrl_write_req && ctrl.ctrl_read_req) both_err <= both_err + 1;
    if (ctrl.ctrl_read_req) rd_cnt <= rd_cnt + 1;
    if (ctrl.ctrl_write_req) begin
      if (pend && cur_w != pend_val) stable_err <= stable_err + 1;
      if (ctrl.ctrl_write_ack) begin
        wr_log.push_back(cur_w);
        wr_cyc.push_back(cyc);
        wr_wait.push_back(wcnt);
        wcnt <= 0;
        pend <= 1'b0;
      end else begin
        wcnt     <= wcnt + 1;
        pend     <= 1'b1;
        pend_val <= cur_w;
      end
    end else begin
      wcnt <= 0;
      pend <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [33:0] w(input int idx, input int val);
    return {2'(idx), 32'(val)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic run_start();
    @(negedge clock);
    rd_base   = rd_cnt;
    log_base  = wr_log.size();
    done_base = done_cnt;
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (done_cnt == done_base && k < bound) begin
      @(negedge clock);
      k++;
    end
    tick(3);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - done_base), 1);
    check_eq({tag, "_busy_after"}, 64'(busy), 0);
  endtask

  task automatic wait_read_req(input string tag, input int bound);
    int k = 0;
    while (!ctrl.ctrl_read_req && k < bound) begin
      @(negedge clock);
      k++;
    end
    check_eq({tag, "_poll_reached"}, 64'(ctrl.ctrl_read_req), 1);
  endtask

  task automatic check_writes(input string tag);
    int n = wr_log.size() - log_base;
    check_eq({tag, "_write_count"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      check_eq($sformatf("%s_write%0d", tag, i), 64'(wr_log[log_base + i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    int bad_wait;
    int k;

    // Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_done", 64'(done), 0);
    check_eq("rst_count", 64'(cycle_count), 0);
    check_eq("rst_reqs", 64'({ctrl.ctrl_write_req, ctrl.ctrl_read_req}), 0);

    // Immediate acks, halted on the 10th POLL cycle; extra start while busy is ignored
    ack_delay = 0;
    halt_at   = 10;
    run_start();
    wait_read_req("s1", 50);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("s1", 100);
    exp_q = '{w(0, 1), w(0, 0), w(1, 1), w(2, 1), w(2, 0), w(1, 0)};
    check_writes("s1");
    if (wr_log.size() - log_base >= 2)
      check_eq("s1_hold_idle_cycles", 64'(wr_cyc[log_base + 1] - wr_cyc[log_base] - 1), 4);
    else
      check_eq("s1_hold_idle_cycles", 64'(0), 4);
    check_eq("s1_cycle_count", 64'(cycle_count), 10);
    check_eq("s1_flags", 64'({timed_out, aborted}), 0);

    // Each write acked 3 cycles late
    ack_delay = 3;
    halt_at   = 3;
    run_start();
    wait_done("s2", 200);
    check_writes("s2");
    bad_wait = 0;
    for (int i = log_base; i < wr_log.size(); i++) if (wr_wait[i] != 3) bad_wait++;
    check_eq("s2_ack_wait", 64'(bad_wait), 0);
    check_eq("s2_stable", 64'(stable_err), 0);
    check_eq("s2_cycle_count", 64'(cycle_count), 3);

    // Timeout limit of 5 POLL cycles
    ack_delay      = 0;
    timeout_cycles = 5;
`ifdef SYSTEM_RUN_SEQUENCER_TIMEOUT_EN
    halt_at = 0;
    run_start();
    wait_done("s3", 100);
    check_writes("s3");
    check_eq("s3_timed_out", 64'(timed_out), 1);
    check_eq("s3_cycle_count", 64'(cycle_count), 5);
`else
    halt_at = 8;
    run_start();
    wait_done("s3", 100);
    check_writes("s3");
    check_eq("s3_timed_out", 64'(timed_out), 0);
    check_eq("s3_cycle_count", 64'(cycle_count), 8);
`endif
    timeout_cycles = 0;

    // Abort while the enable write is waiting for its ack
    ack_delay = 3;
    halt_at   = 0;
    run_start();
    k = 0;
    while (!(ctrl.ctrl_write_req && cur_w == w(1, 1)) && k < 100) begin
      @(negedge clock);
      k++;
    end
    check_eq("s4_en_on_reached", 64'(cur_w == w(1, 1)), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_done("s4", 100);
    exp_q = '{w(0, 1), w(0, 0), w(1, 1), w(2, 0), w(1, 0)};
    check_writes("s4");
    check_eq("s4_aborted", 64'(aborted), 1);
    check_eq("s4_no_polls", 64'(rd_cnt - rd_base), 0);
    check_eq("s4_cycle_count", 64'(cycle_count), 0);

    // Halted, abort (and timeout when enabled) on the same POLL cycle: halted wins
    ack_delay      = 0;
    halt_at        = 2;
    timeout_cycles = 2;
    run_start();
    wait_read_req("s5", 50);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_done("s5", 50);
    check_eq("s5_flags", 64'({timed_out, aborted}), 0);
    check_eq("s5_cycle_count", 64'(cycle_count), 2);
    timeout_cycles = 0;

    // Reset in the middle of POLL
    halt_at = 0;
    run_start();
    wait_read_req("s6", 50);
    tick(3);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_eq("s6_busy", 64'(busy), 0);
    check_eq("s6_read_req", 64'(ctrl.ctrl_read_req), 0);
    check_eq("s6_cycle_count", 64'(cycle_count), 0);
    @(negedge clock);
    reset = 1'b0;

    // Abort while idle does nothing
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(2);
    check_eq("s7_idle_abort", 64'({busy, aborted}), 0);
    check_eq("one_req_at_a_time", 64'(both_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/system_run_sequencer.md
SYSTEM_RUN_SEQUENCER -- requirements
Module: system_run_sequencer

Interface
REQ-001 Parameter RESET_HOLD_CYCLES, default 4, SHALL set the cycles system reset is held high (legal range 1..255).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the control-port data and counter width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle run request
- abort  in  1  single-cycle cancel request
- timeout_cycles  in  DATA_WIDTH  run limit; 0 = none
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- timed_out  out  1  last run hit the limit
- aborted  out  1  last run was cancelled
- cycle_count  out  DATA_WIDTH  POLL cycles of the last/current run
- ctrl_write_req / ctrl_write_ack  out/in  1  control-register write handshake
- ctrl_write_index  out  2  write target
- ctrl_write_data  out  DATA_WIDTH  write value
- ctrl_read_req / ctrl_read_ack  out/in  1  control-register read handshake
- ctrl_read_index  out  2  read target
- ctrl_read_data  in  DATA_WIDTH  read value

Function
REQ-004 Control-register indices SHALL be: reset=0, enable=1, execute=2, halted=3.
REQ-005 The states SHALL be IDLE, RST_ON, RST_HOLD, RST_OFF, EN_ON, EXE_ON, POLL, EXE_OFF, EN_OFF, DONE.
REQ-006 IDLE->RST_ON SHALL occur on start; start while busy SHALL be ignored; start SHALL clear timed_out, aborted, and cycle_count.
REQ-007 Write states SHALL hold write_req with a stable index/data until the cycle write_ack=1, then advance on the next edge; same-cycle ack SHALL be legal.
REQ-008 Write sequence: RST_ON(0,1) -> RST_HOLD, idle for RESET_HOLD_CYCLES -> RST_OFF(0,0) -> EN_ON(1,1) -> EXE_ON(2,1) -> POLL.
REQ-009 POLL SHALL assert read_req with index 3 every cycle; read_ack=1 with read_data[0]=1 SHALL go to EXE_OFF.
REQ-010 cycle_count SHALL increment once per POLL cycle and saturate at all ones.
REQ-011 EXE_OFF(2,0) -> EN_OFF(1,0) -> DONE; DONE SHALL pulse done for one cycle, then go to IDLE.
REQ-012 abort in POLL SHALL go to EXE_OFF next edge; abort in RST_ON..EXE_ON SHALL be latched and taken after the current handshake completes (RST_HOLD exits immediately); aborted SHALL be set.
REQ-013 If halted, abort and timeout coincide, halted SHALL win; aborted and timed_out SHALL both stay 0.
REQ-014 Only one of write_req and read_req SHALL be high in any cycle.
REQ-015 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-016 reset SHALL force IDLE and zero all outputs on the next edge, including mid-handshake; pending abort SHALL clear.

Configuration
REQ-017 With SYSTEM_RUN_SEQUENCER_TIMEOUT_EN defined: when timeout_cycles!=0 and cycle_count reaches timeout_cycles in POLL, timed_out SHALL be set and the state SHALL go to EXE_OFF.
REQ-018 Without SYSTEM_RUN_SEQUENCER_TIMEOUT_EN: timeout_cycles SHALL be ignored, timed_out SHALL be constant 0, and POLL SHALL end only on halted or abort.

Verification
REQ-019 Acks always high, start, halted=1 at 10th POLL cycle -> writes (0,1),(0,0) 4 cycles apart, (1,1),(2,1),(2,0),(1,0); cycle_count=10; done pulse once.
REQ-020 write_ack delayed 3 cycles on each write -> req/index/data stable throughout; ordering unchanged.
REQ-021 TIMEOUT_EN, timeout_cycles=5, halted never -> timed_out=1, cycle_count=5, execute then enable cleared, done pulse.
REQ-022 abort during EN_ON with ack delayed -> EN_ON completes, then EXE_OFF, EN_OFF, aborted=1, no EXE_ON write.
REQ-023 reset asserted mid-POLL -> next edge busy=0, read_req=0, cycle_count=0; start while busy ignored.
